// File: rtl/fetch_ctrl_pkg.sv
// Shared definitions for the instruction-fetch control path: FSM state
// encoding, next-PC source selects and the fixed PC constants used by the
// PC mux.
package fetch_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_RESET     = 3'd0,
    ST_RUN       = 3'd1,
    ST_IMM       = 3'd2,
    ST_INT_DRAIN = 3'd3,
    ST_INT_SAVE  = 3'd4,
    ST_INT_VEC   = 3'd5
  } fetch_state_e;

  localparam logic [1:0] PCSEL_SEQ    = 2'd0;
  localparam logic [1:0] PCSEL_BRANCH = 2'd1;
  localparam logic [1:0] PCSEL_VECTOR = 2'd2;
  localparam logic [1:0] PCSEL_RESET  = 2'd3;

  localparam logic [31:0] RESET_PC   = 32'h20;
  localparam logic [31:0] INT_VECTOR = 32'h0;

  // A new interrupt request is only recorded while fetching normally; during
  // an entry sequence it merges into the entry already in flight.
  function automatic logic irq_can_arm(fetch_state_e st);
    return (st == ST_RUN) || (st == ST_IMM);
  endfunction

endpackage

// File: rtl/fetch_sequencer_irq_pending_reg.sv
// Interrupt pending flag: armed set from the request line, cleared when the
// vector is loaded. Clear wins over set so the flag re-arms only afterwards.
module irq_pending_reg (
  input  logic clk,
  input  logic rst,
  input  logic req_i,
  input  logic arm_i,
  input  logic clr_i,
  output logic pending_o
);

  logic pending_q;
  logic pending_d;

  // Next-state: hold, set on an armed request, clear overrides set.
  always_comb begin
    pending_d = pending_q;
    if (req_i && arm_i) begin
      pending_d = 1'b1;
    end
    if (clr_i) begin
      pending_d = 1'b0;
    end
  end

  // Flag register; requests seen while rst is high are dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q <= 1'b0;
    end else begin
      pending_q <= pending_d;
    end
  end

  assign pending_o = pending_q;

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch-stage control FSM: chooses the next-PC source, PC write enable and
// IF/ID flush each cycle, keeps two-word instructions together, and walks
// interrupt entry through drain, return-PC save and vector load.
module fetch_sequencer #(
  parameter int PC_W         = 32,
  parameter int DRAIN_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            hazardStall,
  input  logic            jumpBit,
  input  logic [PC_W-1:0] branchTarget,
  input  logic            interruptReq,
  input  logic            isImmInstr,
  input  logic [PC_W-1:0] currentPc,
  output logic [1:0]      pcSel,
  output logic            pcWrite,
  output logic            flushIF,
  output logic            intAck,
  output logic            savePcValid,
  output logic [PC_W-1:0] savedPc
);

  import fetch_ctrl_pkg::*;

  localparam logic [2:0] DRAIN_LAST = 3'(DRAIN_CYCLES - 1);

  fetch_state_e    state_q, state_d;
  logic [2:0]      drain_cnt_q, drain_cnt_d;
  logic [PC_W-1:0] saved_pc_q, saved_pc_d;
  logic            pending;
  logic            pending_clr;

  irq_pending_reg u_irq_pending (
    .clk       (clk),
    .rst       (rst),
    .req_i     (interruptReq),
    .arm_i     (irq_can_arm(state_q)),
    .clr_i     (pending_clr),
    .pending_o (pending)
  );

  // Next-state and Mealy PC controls; rst forces the reset-vector load.
  always_comb begin
    state_d     = state_q;
    drain_cnt_d = 3'd0;
    saved_pc_d  = saved_pc_q;
    pending_clr = 1'b0;
    pcSel       = PCSEL_SEQ;
    pcWrite     = 1'b0;
    flushIF     = 1'b0;

    unique case (state_q)
      ST_RESET: begin
        pcSel   = PCSEL_RESET;
        pcWrite = 1'b1;
        flushIF = 1'b1;
        state_d = ST_RUN;
      end
      ST_RUN: begin
        if (jumpBit) begin
          pcSel   = PCSEL_BRANCH;
          pcWrite = 1'b1;
          flushIF = 1'b1;
        end else if (pending && !hazardStall) begin
          // The word at currentPc is squashed and becomes the return address.
          saved_pc_d = currentPc;
          flushIF    = 1'b1;
          state_d    = ST_INT_DRAIN;
        end else if (hazardStall) begin
          pcWrite = 1'b0;
        end else if (isImmInstr) begin
          pcWrite = 1'b1;
          state_d = ST_IMM;
        end else begin
          pcWrite = 1'b1;
        end
      end
      ST_IMM: begin
        if (jumpBit) begin
          pcSel   = PCSEL_BRANCH;
          pcWrite = 1'b1;
          flushIF = 1'b1;
          state_d = ST_RUN;
        end else if (!hazardStall) begin
          pcWrite = 1'b1;
          state_d = ST_RUN;
        end
      end
      ST_INT_DRAIN: begin
        flushIF = 1'b1;
        // A branch resolving from an older instruction redefines where the
        // interrupted program resumes.
        if (jumpBit) begin
          saved_pc_d = branchTarget;
        end
        if (drain_cnt_q == DRAIN_LAST) begin
          state_d = ST_INT_SAVE;
        end else begin
          drain_cnt_d = drain_cnt_q + 3'd1;
        end
      end
      ST_INT_SAVE: begin
        flushIF = 1'b1;
        state_d = ST_INT_VEC;
      end
      ST_INT_VEC: begin
        pcSel       = PCSEL_VECTOR;
        pcWrite     = 1'b1;
        flushIF     = 1'b1;
        pending_clr = 1'b1;
        state_d     = ST_RUN;
      end
      default: begin
        pcSel   = PCSEL_RESET;
        pcWrite = 1'b1;
        flushIF = 1'b1;
        state_d = ST_RESET;
      end
    endcase

    if (rst) begin
      pcSel   = PCSEL_RESET;
      pcWrite = 1'b1;
      flushIF = 1'b1;
    end
  end

  // State, drain counter and return-PC registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_RESET;
      drain_cnt_q <= 3'd0;
      saved_pc_q  <= '0;
    end else begin
      state_q     <= state_d;
      drain_cnt_q <= drain_cnt_d;
      saved_pc_q  <= saved_pc_d;
    end
  end

  // Strobes are pure state decodes, suppressed while rst abandons an entry.
  assign intAck      = !rst && (state_q == ST_INT_VEC);
  assign savePcValid = !rst && (state_q == ST_INT_SAVE);
  assign savedPc     = saved_pc_q;

endmodule
